// File: rtl/video_timing_gen_if.sv
// Pixel ready/valid bus between the frame-buffer FIFO (master) and the
// raster timing generator (slave).
interface video_timing_gen_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (
      output pix_data,
      output pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: lock-gated H/V counters, registered sync/DE/coordinate
// outputs, and a pixel pull path from the frame-buffer FIFO with sticky underflow.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pll_locked,
   video_timing_gen_if.slave        pix_if,
   input  logic                     underflow_clr,
   output logic                     hsync,
   output logic                     vsync,
   output logic                     de,
   output logic [23:0]              rgb,
   output logic [10:0]              x,
   output logic [9:0]               y,
   output logic                     frame_start,
   output logic                     line_start,
   output logic                     underflow
);

   localparam logic [10:0] H_A_END = 11'(H_ACTIVE);
   localparam logic [10:0] H_F_END = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_S_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

   localparam logic [9:0]  V_A_END = 10'(V_ACTIVE);
   localparam logic [9:0]  V_F_END = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   localparam logic [1:0] StActive = 2'd0;
   localparam logic [1:0] StFp     = 2'd1;
   localparam logic [1:0] StSync   = 2'd2;
   localparam logic [1:0] StBp     = 2'd3;

   logic        lock_meta_q;
   logic        run_q;

   logic [10:0] h_cnt_d, h_cnt_q;
   logic [9:0]  v_cnt_d, v_cnt_q;
   logic [1:0]  h_state, v_state;

   logic        pix_ready;
   logic        pix_take;

   logic        hsync_d, hsync_q;
   logic        vsync_d, vsync_q;
   logic        de_d, de_q;
   logic [23:0] rgb_d, rgb_q;
   logic [10:0] x_d, x_q;
   logic [9:0]  y_d, y_q;
   logic        frame_start_d, frame_start_q;
   logic        line_start_d, line_start_q;
   logic        underflow_d, underflow_q;

   // Two-flop synchronizer for the PLL lock, which is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         run_q       <= lock_meta_q;
      end
   end

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run_q) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
         h_cnt_d = h_cnt_q + 11'd1;
      end
   end

   always_comb begin
      if (h_cnt_q < H_A_END) begin
         h_state = StActive;
      end else if (h_cnt_q < H_F_END) begin
         h_state = StFp;
      end else if (h_cnt_q < H_S_END) begin
         h_state = StSync;
      end else begin
         h_state = StBp;
      end
   end

   always_comb begin
      if (v_cnt_q < V_A_END) begin
         v_state = StActive;
      end else if (v_cnt_q < V_F_END) begin
         v_state = StFp;
      end else if (v_cnt_q < V_S_END) begin
         v_state = StSync;
      end else begin
         v_state = StBp;
      end
   end

   assign pix_ready        = run_q && (h_state == StActive) && (v_state == StActive);
   assign pix_take         = pix_ready && pix_if.pix_valid;
   assign pix_if.pix_ready = pix_ready;

   // Every output except pix_ready is the registered image of the current counters,
   // forced to idle values while the PLL is not locked.
   always_comb begin
      hsync_d       = ~SYNC_POL;
      vsync_d       = ~SYNC_POL;
      de_d          = 1'b0;
      rgb_d         = '0;
      x_d           = '0;
      y_d           = '0;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;
      if (run_q) begin
         hsync_d       = (h_state == StSync) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = (v_state == StSync) ? SYNC_POL : ~SYNC_POL;
         de_d          = pix_ready;
         rgb_d         = pix_take ? pix_if.pix_data : '0;
         x_d           = pix_ready ? h_cnt_q : '0;
         y_d           = pix_ready ? v_cnt_q : '0;
         frame_start_d = pix_ready && (h_cnt_q == '0) && (v_cnt_q == '0);
         line_start_d  = pix_ready && (h_cnt_q == '0);
      end
   end

   // A missed pixel outranks a simultaneous clear so no underflow goes unreported.
   always_comb begin
      underflow_d = underflow_q;
      if (pix_ready && !pix_if.pix_valid) begin
         underflow_d = 1'b1;
      end else if (underflow_clr) begin
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign underflow   = underflow_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Pixel-clock raster timing generator for the video output path. It runs on the 25 MHz pixel clock from the video PLL and is gated by that PLL's `locked` output. It produces registered HSYNC/VSYNC/DE, pixel coordinates and frame/line strobes. It pulls RGB pixels from the upstream frame-buffer FIFO over a ready/valid handshake and drives them to the DAC/HDMI encoder, aligned to DE.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync active level (0 = active-low)

Ports:
- `clk` in 1: pixel clock, the PLL `outclk_0`.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `pix_data` in 24: RGB888 from the upstream FIFO.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_ready` out 1: combinational; a pixel is consumed this cycle when `pix_ready` and `pix_valid` are both high.
- `underflow_clr` in 1: clears `underflow`.
- `hsync` out 1: registered horizontal sync.
- `vsync` out 1: registered vertical sync.
- `de` out 1: registered data enable.
- `rgb` out 24: registered pixel, aligned to `de`.
- `x` out 11: registered column.
- `y` out 10: registered row.
- `frame_start` out 1: 1-cycle pulse with the first `de` of each frame.
- `line_start` out 1: 1-cycle pulse with the first `de` of each active line.
- `underflow` out 1: sticky; a pixel was missing during active video.

## Operation
Lock synchronization:
- `pll_locked` passes through a 2-flop synchronizer, giving `run`.
- When `run`=0, `h_cnt` and `v_cnt` are held at 0, `pix_ready` is 0 and all outputs sit at their reset values.

Counters:
- `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800).
- `v_cnt` runs 0..V_TOTAL-1 (525).
- `v_cnt` increments when `h_cnt` wraps. Both wrap to 0 at the frame end.
- Counter widths: 11 bits horizontal, 10 bits vertical. Parameters must give totals below 2048 and 1024 respectively.

Regions (each axis has an FSM state ACTIVE → FP → SYNC → BP → ACTIVE, derived from its counter):
- ACTIVE: cnt < ACTIVE
- FP: ACTIVE ≤ cnt < ACTIVE+FP
- SYNC: ACTIVE+FP ≤ cnt < ACTIVE+FP+SYNC
- BP: the remainder

Pixel path:
- `pix_ready` = `run` && h ACTIVE && v ACTIVE.
- Next-cycle outputs:
  - `de` = `pix_ready`.
  - `x`/`y` = `h_cnt`/`v_cnt` when in the active region, else 0.
  - `hsync` = SYNC_POL when h is in SYNC, else ~SYNC_POL.
  - `vsync` = SYNC_POL when v is in SYNC, else ~SYNC_POL. `vsync` changes only at `h_cnt`=0.
  - `rgb` = `pix_data` if `pix_ready` && `pix_valid`, else 24'h0.
- Underflow:
  - `pix_ready` && !`pix_valid` → `rgb` is black for that pixel and `underflow` sets.
  - Raster timing never stalls on underflow.
  - `underflow_clr` clears `underflow`. If a clear and a new underflow occur in the same cycle, set wins.
- Strobes:
  - `frame_start` is registered from `pix_ready` at (0,0).
  - `line_start` is registered from `pix_ready` at h_cnt=0.

Lock loss:
- `run` falling mid-frame returns counters to (0,0) and outputs to reset values on the next edge.
- When lock returns, the raster restarts at a fresh frame.

## Timing
Reset values:
- `hsync` = `vsync` = ~SYNC_POL.
- `de`, `frame_start`, `line_start`, `underflow`, `pix_ready` = 0.
- `rgb`, `x`, `y` = 0.

Lock latency:
- `pll_locked` rising at edge N gives `run`=1 after edge N+2.
- The counter is at (0,0) with `pix_ready`=1 during the cycle following edge N+2.
- First `de`/`frame_start` appears after edge N+3.

Handshake and output latency:
- `pix_ready` is same-cycle combinational from the counters.
- All other outputs lag the counters by exactly 1 clock.
- `pix_data` is sampled on the same edge that consumes it and appears on `rgb` after that edge.

Line and frame timing (default parameters):
- Per line: 640 `de` clocks, then 16 clocks idle, 96 clocks `hsync`=0, 48 clocks idle; period 800.
- Per frame: 420000 clocks; `vsync` low for 1600 clocks starting 490 lines after `frame_start`.

## Test plan
- Reset/no-lock: assert `rst`, hold `pll_locked`=0 for 1000 clocks → `hsync`=`vsync`=1, `de`=0, `rgb`=0, `pix_ready`=0 throughout.
- Lock start: raise `pll_locked` → `frame_start` exactly 3 edges later with `x`=0, `y`=0, `de`=1.
- Line timing: `pix_valid` tied 1 → `de` high for 640 clocks; `hsync` falls 656 clocks after `de` rises and stays low for 96; `line_start` period is 800 clocks.
- Frame timing: run 2 frames → `frame_start` period is 420000; `vsync` low for 2 lines beginning at line 490; `y` max is 479, `x` max is 639.
- Underflow: drop `pix_valid` for pixel (100,5) → `rgb`=0 for that pixel only, `underflow`=1 and stays set; pulse `underflow_clr` → `underflow`=0. Simultaneous clear and miss → `underflow` stays 1.
- Lock loss: drop `pll_locked` at line 200 → within 3 edges all outputs return to reset values. Re-lock → `frame_start` at (0,0) 3 edges later and `underflow` is unaffected.
